level_pwm: RTL and testbench

- Downstream stage of the monostable timer.
- Consumes the 8-bit "incomplete" level (255 = just triggered, 0 = expired) and drives a glitch-free PWM output for an LED or indicator, so brightness decays as the monostable runs out.
- Duty changes are applied only at PWM period boundaries and are slew-limited for smooth fades.

---
 rtl/pv_audio_pkg.sv | 37 +++
 rtl/level_pwm_if.sv | 14 +
 rtl/pwm_prescaler.sv | 30 +++
 rtl/level_pwm.sv | 82 ++++++++
 tb/tb_level_pwm.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pv_audio_pkg.sv
// Shared types and helpers for the monostable timer / PWM indicator chain.
// Optional gamma helper is built only when LEVEL_PWM_GAMMA_EN is defined.
package pv_audio_pkg;

  localparam int PWM_PERIOD = 255;
  localparam int LEVEL_W    = 8;

  typedef logic [LEVEL_W-1:0] level_t;

  // Move cur toward tgt by at most max_step, never overshooting or wrapping.
  function automatic level_t slew_step(level_t cur, level_t tgt, level_t max_step);
    logic [LEVEL_W:0] diff;
    level_t           result;
    diff   = {1'b0, max_step};
    result = cur;
    if (tgt > cur) begin
      diff   = {1'b0, tgt} - {1'b0, cur};
      result = (diff > {1'b0, max_step}) ? (cur + max_step) : tgt;
    end else if (tgt < cur) begin
      diff   = {1'b0, cur} - {1'b0, tgt};
      result = (diff > {1'b0, max_step}) ? (cur - max_step) : tgt;
    end else begin
      result = cur;
    end
    return result;
  endfunction

`ifdef LEVEL_PWM_GAMMA_EN
  // Square-law perceptual curve; 255*255+255 still fits in 16 bits.
  function automatic level_t gamma_correct(level_t d);
    logic [15:0] sq;
    sq = ({8'd0, d} * {8'd0, d}) + 16'd255;
    return sq[15:8];
  endfunction
`endif

endpackage

// File: rtl/level_pwm_if.sv
// Control/status bundle between the monostable level source and level_pwm.
interface level_pwm_if;
  import pv_audio_pkg::*;

  logic   en;
  level_t level;
  logic   pwm_out;
  level_t duty;
  logic   period_start;

  modport master (output en, output level, input pwm_out, input duty, input period_start);
  modport slave  (input en, input level, output pwm_out, output duty, output period_start);

endinterface

// File: rtl/pwm_prescaler.sv
// Reusable tick generator: tick is high while the counter sits at PRESCALE-1.
module pwm_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST_C = 16'(PRESCALE - 1);

  logic [15:0] count_r;

  assign tick = (count_r == LAST_C);

  // Free-running divider, synchronously parked at zero by clr.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (tick) begin
      count_r <= 16'd0;
    end else begin
      count_r <= count_r + 16'd1;
    end
  end

endmodule

// File: rtl/level_pwm.sv
// Glitch-free, slew-limited PWM driver for the monostable "incomplete" level.
// Define LEVEL_PWM_GAMMA_EN to apply a square-law curve to the compared duty.
module level_pwm
  import pv_audio_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned SLEW     = 255
) (
  input  logic        sys_clk,
  input  logic        rst,
  level_pwm_if.slave  bus
);

  localparam level_t SLEW_C   = level_t'(SLEW);
  localparam level_t CNT_LAST = level_t'(PWM_PERIOD - 1);

  logic   tick_s;
  logic   clr_s;
  logic   boundary_s;
  level_t duty_eff_s;
  level_t cnt_r;
  level_t duty_cur_r;
  logic   pwm_r;
  logic   period_start_r;

  assign clr_s = ~bus.en;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  // Boundary is decided from register state so a same-edge enable drop still updates duty.
  assign boundary_s = tick_s && (cnt_r == CNT_LAST);

`ifdef LEVEL_PWM_GAMMA_EN
  assign duty_eff_s = gamma_correct(duty_cur_r);
`else
  assign duty_eff_s = duty_cur_r;
`endif

  // Period counter, boundary duty update and registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_r          <= 8'd0;
      duty_cur_r     <= 8'd0;
      pwm_r          <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      if (boundary_s) begin
        duty_cur_r <= slew_step(duty_cur_r, bus.level, SLEW_C);
      end else begin
        duty_cur_r <= duty_cur_r;
      end

      if (!bus.en) begin
        cnt_r          <= 8'd0;
        pwm_r          <= 1'b0;
        period_start_r <= 1'b0;
      end else begin
        if (boundary_s) begin
          cnt_r <= 8'd0;
        end else if (tick_s) begin
          cnt_r <= cnt_r + 8'd1;
        end else begin
          cnt_r <= cnt_r;
        end
        pwm_r          <= (cnt_r < duty_eff_s);
        period_start_r <= boundary_s;
      end
    end
  end

  assign bus.pwm_out      = pwm_r;
  assign bus.duty         = duty_cur_r;
  assign bus.period_start = period_start_r;

endmodule

// File: tb/tb_level_pwm.sv
// Randomised self-checking bench for level_pwm against a time-based reference model.
module tb_level_pwm;
  import pv_audio_pkg::*;

  localparam int P   = 2;
  localparam int SL  = 16;
  localparam int PER = 255 * P;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  level_pwm_if bus ();

  level_pwm #(
    .PRESCALE (P),
    .SLEW     (SL)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: cycles elapsed since counting (re)started, and the applied duty.
  int m_k    = 0;
  int m_duty = 0;
  int m_pwm  = 0;
  int m_ps   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
`ifdef LEVEL_PWM_GAMMA_EN
    return (d * d + 255) / 256;
`else
    return d;
`endif
  endfunction

  function automatic int slew(input int cur, input int tgt);
    if (tgt > cur) return cur + ((tgt - cur) < SL ? (tgt - cur) : SL);
    if (tgt < cur) return cur - ((cur - tgt) < SL ? (cur - tgt) : SL);
    return cur;
  endfunction

  task automatic model_reset();
    m_k = 0; m_duty = 0; m_pwm = 0; m_ps = 0;
  endtask

  // One sys_clk: advance the model at the rising edge, compare at the falling edge.
  task automatic clk_cycle();
    int  cnt_now;
    bit  bnd;
    @(posedge sys_clk);
    if (rst) begin
      model_reset();
    end else begin
      cnt_now = (m_k / P) % 255;
      bnd     = (m_k % PER) == (PER - 1);
      m_pwm   = (bus.en && (cnt_now < eff(m_duty))) ? 1 : 0;
      m_ps    = (bus.en && bnd) ? 1 : 0;
      if (bnd) m_duty = slew(m_duty, int'(bus.level));
      m_k     = bus.en ? m_k + 1 : 0;
    end
    @(negedge sys_clk);
    check_val("pwm_out", int'(bus.pwm_out), m_pwm);
    check_val("duty", int'(bus.duty), m_duty);
    check_val("period_start", int'(bus.period_start), m_ps);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  task automatic wait_ps(input string tag, output int cycles);
    cycles = 0;
    while (cycles < 2 * PER) begin
      clk_cycle();
      cycles++;
      if (bus.period_start) break;
    end
    if (!bus.period_start) check_val(tag, 0, 1);
  endtask

  task automatic count_high(input int n, input int change_at, input int new_level, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (i == change_at) bus.level = level_t'(new_level);
      clk_cycle();
      hi += int'(bus.pwm_out);
    end
  endtask

  initial begin
    int cyc;
    int hi;
    bus.en    = 1'b0;
    bus.level = 8'd0;
    rst       = 1'b1;
    #12;
    check_val("reset_pwm", int'(bus.pwm_out), 0);
    check_val("reset_duty", int'(bus.duty), 0);
    check_val("reset_ps", int'(bus.period_start), 0);
    @(negedge sys_clk);
    rst = 1'b0;
    model_reset();

    // Static zero duty for three periods.
    bus.en = 1'b1;
    run(3 * PER);

    // Ramp to full scale, then confirm a full-on period.
    bus.level = 8'd255;
    run(17 * PER);
    wait_ps("ps_full", cyc);
    count_high(PER, -1, 0, hi);
    check_val("full_high", hi, eff(255) * P);

    // Partial duty 64.
    bus.level = 8'd64;
    run(13 * PER);
    wait_ps("ps_64", cyc);
    count_high(PER, -1, 0, hi);
    check_val("duty64_high", hi, eff(64) * P);

    // Mid-period change 200 -> 10 at cnt=50 keeps this period at 200.
    bus.level = 8'd200;
    run(10 * PER);
    wait_ps("ps_200", cyc);
    count_high(PER, 100, 10, hi);
    check_val("midchange_high", hi, eff(200) * P);
    run(3 * PER);

    // Enable drop at cnt=100, then resume and time the first boundary.
    wait_ps("ps_en", cyc);
    run(199);
    bus.en = 1'b0;
    run(50);
    bus.en = 1'b1;
    wait_ps("ps_resume", cyc);
    check_val("resume_cycles", cyc, PER);

    // Enable dropped exactly on a boundary edge: duty must still move.
    bus.level = 8'd250;
    cyc = 0;
    while (((m_k % PER) != (PER - 1)) && (cyc < 2 * PER)) begin
      clk_cycle();
      cyc++;
    end
    check_val("bnd_reached", int'((m_k % PER) == (PER - 1)), 1);
    bus.en = 1'b0;
    run(20);
    bus.en = 1'b1;

    // Randomised level and enable activity.
    for (int i = 0; i < 20000; i++) begin
      clk_cycle();
      if ($urandom_range(0, 299) == 0) bus.level = level_t'($urandom_range(0, 255));
      if ($urandom_range(0, 1499) == 0) bus.en = ~bus.en;
    end

    // Asynchronous reset between edges.
    bus.en    = 1'b1;
    bus.level = 8'd255;
    run(20 * PER);
    run(137);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_pwm", int'(bus.pwm_out), 0);
    check_val("async_duty", int'(bus.duty), 0);
    check_val("async_ps", int'(bus.period_start), 0);
    model_reset();
    clk_cycle();
    rst = 1'b0;
    run(3 * PER);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
